// File: rtl/uart_pwm_pkg.sv
// Shared definitions for the UART-to-PWM command parser: command byte codes,
// parser state encoding and small sizing helpers.
package uart_pwm_pkg;

    localparam logic [7:0] CMD_DUTY = 8'h44;  // 'D'
    localparam logic [7:0] CMD_FREQ = 8'h46;  // 'F'
    localparam logic [7:0] CMD_EN   = 8'h45;  // 'E'

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StGetCh  = 2'd1,
        StGetVal = 2'd2,
        StGetChk = 2'd3
    } parse_state_e;

    // Width of a counter indexing nbytes value bytes (at least 1 bit).
    function automatic int unsigned byte_cnt_w(input int unsigned nbytes);
        return (nbytes <= 1) ? 1 : $clog2(nbytes);
    endfunction

    function automatic logic is_cmd(input logic [7:0] b);
        return (b == CMD_DUTY) || (b == CMD_FREQ) || (b == CMD_EN);
    endfunction

endpackage

// File: rtl/cmd_timeout_timer.sv
// Inter-byte timeout timer. Counts cycles while run_i is high and no byte
// arrives; expire_o pulses on the TIMEOUT_CYC-th idle cycle. TIMEOUT_CYC = 0
// disables the timer entirely.
module cmd_timeout_timer #(
    parameter int unsigned TIMEOUT_CYC = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic run_i,
    output logic expire_o
);

    if (TIMEOUT_CYC == 0) begin : g_off
        logic unused_sig;
        assign unused_sig = ^{clk, rst, clear_i, run_i};
        assign expire_o   = 1'b0;
    end else begin : g_on
        localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);

        logic [CntW-1:0] cnt_q, cnt_d;
        logic            hit;

        assign hit = (cnt_q == CntW'(TIMEOUT_CYC - 1));
        // An arriving byte always beats a simultaneous expiry.
        assign expire_o = run_i && !clear_i && hit;

        // Next count: restart on byte, when idle, or after expiry.
        always_comb begin
            cnt_d = cnt_q + CntW'(1);
            if (clear_i || !run_i || hit) begin
                cnt_d = '0;
            end
        end

        // Count register.
        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end
    end

endmodule

// File: rtl/multi_cmd_parser.sv
// Multi-channel UART command parser. Decodes CMD, CH, VALUE[, CHK] byte frames
// into per-channel duty / frequency / enable registers.
// Build option: CMD_CHECKSUM_EN appends an XOR checksum byte to every frame.
module multi_cmd_parser
    import uart_pwm_pkg::*;
#(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned TIMEOUT_CYC = 1000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rx_valid,
    input  logic [7:0]               rx_data,
    output logic [NUM_CH*DATA_W-1:0] duty_cycle,
    output logic [NUM_CH*DATA_W-1:0] freq_div,
    output logic [NUM_CH-1:0]        enable_pwm,
    output logic                     cmd_done,
    output logic                     cmd_error
);

    localparam int unsigned NBytes = DATA_W / 8;
    localparam int unsigned BCntW  = byte_cnt_w(NBytes);

    parse_state_e      state_q, state_d;
    logic [7:0]        cmd_q, cmd_d;
    logic [7:0]        ch_q, ch_d;
    logic [DATA_W-1:0] shadow_q, shadow_d;
    logic [BCntW-1:0]  bcnt_q, bcnt_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              commit;
    logic [DATA_W-1:0] wr_val;
    logic              ch_ok;
    logic              last_val;
    logic              expire;
`ifdef CMD_CHECKSUM_EN
    logic [7:0]        chk_q, chk_d;
`endif

    assign ch_ok    = ({1'b0, ch_q} < 9'(NUM_CH));
    assign last_val = (cmd_q == CMD_EN) || (bcnt_q == BCntW'(NBytes - 1));

    cmd_timeout_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (rx_valid),
        .run_i    (state_q != StIdle),
        .expire_o (expire)
    );

    // Frame FSM: next state, shadow capture and commit decision.
    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        ch_d     = ch_q;
        shadow_d = shadow_q;
        bcnt_d   = bcnt_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        commit   = 1'b0;
        wr_val   = shadow_q;
`ifdef CMD_CHECKSUM_EN
        chk_d    = chk_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (rx_valid) begin
                    if (is_cmd(rx_data)) begin
                        cmd_d   = rx_data;
                        state_d = StGetCh;
`ifdef CMD_CHECKSUM_EN
                        chk_d   = rx_data;
`endif
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StGetCh: begin
                if (rx_valid) begin
                    ch_d     = rx_data;
                    bcnt_d   = '0;
                    shadow_d = '0;
                    state_d  = StGetVal;
`ifdef CMD_CHECKSUM_EN
                    chk_d    = chk_q ^ rx_data;
`endif
                end else if (expire) begin
                    state_d = StIdle;
                    err_d   = 1'b1;
                end
            end
            StGetVal: begin
                if (rx_valid) begin
                    shadow_d = (shadow_q << 8) | DATA_W'(rx_data);
                    bcnt_d   = bcnt_q + BCntW'(1);
`ifdef CMD_CHECKSUM_EN
                    chk_d    = chk_q ^ rx_data;
                    if (last_val) begin
                        state_d = StGetChk;
                    end
`else
                    if (last_val) begin
                        state_d = StIdle;
                        wr_val  = shadow_d;
                        commit  = ch_ok;
                        done_d  = ch_ok;
                        err_d   = !ch_ok;
                    end
`endif
                end else if (expire) begin
                    state_d  = StIdle;
                    shadow_d = '0;
                    err_d    = 1'b1;
                end
            end
            StGetChk: begin
`ifdef CMD_CHECKSUM_EN
                if (rx_valid) begin
                    state_d = StIdle;
                    commit  = ch_ok && (rx_data == chk_q);
                    done_d  = commit;
                    err_d   = !commit;
                end else if (expire) begin
                    state_d  = StIdle;
                    shadow_d = '0;
                    err_d    = 1'b1;
                end
`else
                state_d = StIdle;
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    // Parser state and frame-capture registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cmd_q    <= '0;
            ch_q     <= '0;
            shadow_q <= '0;
            bcnt_q   <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
`ifdef CMD_CHECKSUM_EN
            chk_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            ch_q     <= ch_d;
            shadow_q <= shadow_d;
            bcnt_q   <= bcnt_d;
            done_q   <= done_d;
            err_q    <= err_d;
`ifdef CMD_CHECKSUM_EN
            chk_q    <= chk_d;
`endif
        end
    end

    assign cmd_done  = done_q;
    assign cmd_error = err_q;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic [DATA_W-1:0] duty_q, freq_q;
        logic              en_q;
        logic              sel;

        assign sel = commit && (ch_q == 8'(k));

        // Channel k target registers; only the addressed field is written.
        always_ff @(posedge clk) begin
            if (rst) begin
                duty_q <= '0;
                freq_q <= '0;
                en_q   <= 1'b0;
            end else if (sel) begin
                if (cmd_q == CMD_DUTY) duty_q <= wr_val;
                if (cmd_q == CMD_FREQ) freq_q <= wr_val;
                if (cmd_q == CMD_EN)   en_q   <= wr_val[0];
            end
        end

        assign duty_cycle[k*DATA_W +: DATA_W] = duty_q;
        assign freq_div[k*DATA_W +: DATA_W]   = freq_q;
        assign enable_pwm[k]                  = en_q;
    end

endmodule

// File: tb/tb_multi_cmd_parser.sv
// Scoreboard bench for multi_cmd_parser (NUM_CH=4, DATA_W=16, TIMEOUT_CYC=50).
// Stimulus pushes the expected pulse (kind, cycle, full output snapshot);
// a negedge monitor pops and compares on every cmd_done / cmd_error.
module tb_multi_cmd_parser;

    localparam int NCH = 4;
    localparam int DW  = 16;
    localparam int TO  = 50;

    localparam logic [7:0] C_D = 8'h44;
    localparam logic [7:0] C_F = 8'h46;
    localparam logic [7:0] C_E = 8'h45;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              rx_valid = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic [NCH*DW-1:0] duty_cycle, freq_div;
    logic [NCH-1:0]    enable_pwm;
    logic              cmd_done, cmd_error;

    multi_cmd_parser #(
        .NUM_CH      (NCH),
        .DATA_W      (DW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .duty_cycle (duty_cycle),
        .freq_div   (freq_div),
        .enable_pwm (enable_pwm),
        .cmd_done   (cmd_done),
        .cmd_error  (cmd_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        is_err;
        int          at;
        logic [63:0] duty;
        logic [63:0] freq;
        logic [3:0]  en;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   n_vec  = 0;
    int   n_fail = 0;
    int   last_cyc = 0;

    logic [15:0] m_duty[NCH];
    logic [15:0] m_freq[NCH];
    logic [3:0]  m_en;

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NCH; i++) begin
            m_duty[i] = '0;
            m_freq[i] = '0;
        end
        m_en = '0;
    endtask

    task automatic push(input logic is_err, input int at);
        exp_t e;
        e.is_err = is_err;
        e.at     = at;
        for (int i = 0; i < NCH; i++) begin
            e.duty[i*16 +: 16] = m_duty[i];
            e.freq[i*16 +: 16] = m_freq[i];
        end
        e.en = m_en;
        sbq.push_back(e);
    endtask

    // Byte is sampled by the next posedge; last_cyc is that edge's number.
    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #1;
        last_cyc = cyc;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] cmd, input logic [7:0] ch,
                              input logic [15:0] val, input logic good_chk);
        int         nv;
        logic [7:0] x;
        logic [7:0] b;
        logic       ok;
        nv = (cmd == C_E) ? 1 : 2;
        x  = cmd ^ ch;
        send_byte(cmd);
        send_byte(ch);
        for (int i = nv - 1; i >= 0; i--) begin
            b = val[8*i +: 8];
            x = x ^ b;
            send_byte(b);
        end
        ok = (ch < NCH);
`ifdef CMD_CHECKSUM_EN
        send_byte(good_chk ? x : 8'h00);
        ok = ok && good_chk;
`endif
        if (ok) begin
            if (cmd == C_D) m_duty[ch[1:0]] = val;
            if (cmd == C_F) m_freq[ch[1:0]] = val;
            if (cmd == C_E) m_en[ch[1:0]]   = val[0];
        end
        push(!ok, last_cyc);
    endtask

    // Monitor: every pulse must match the oldest expected response.
    always @(negedge clk) begin
        if (!rst && (cmd_done || cmd_error)) begin
            cmp("done_and_error_exclusive", {63'd0, cmd_done & cmd_error}, 64'd0);
            if (sbq.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL unexpected_pulse: got done=%b error=%b, expected none (cycle %0d)",
                         cmd_done, cmd_error, cyc);
            end else begin
                mon_e = sbq.pop_front();
                cmp("pulse_kind_error", {63'd0, cmd_error}, {63'd0, mon_e.is_err});
                cmp("pulse_cycle", 64'(cyc), 64'(mon_e.at));
                cmp("duty_cycle", duty_cycle, mon_e.duty);
                cmp("freq_div", freq_div, mon_e.freq);
                cmp("enable_pwm", {60'd0, enable_pwm}, {60'd0, mon_e.en});
            end
        end
    end

    initial begin
        model_clear();
        rst = 1'b1;
        idle(3);
        cmp("reset_duty", duty_cycle, 64'd0);
        cmp("reset_freq", freq_div, 64'd0);
        cmp("reset_en", {60'd0, enable_pwm}, 64'd0);
        cmp("reset_pulses", {62'd0, cmd_done, cmd_error}, 64'd0);
        rst = 1'b0;

        // Duty write to channel 2, back-to-back bytes.
        send_frame(C_D, 8'd2, 16'h1234, 1'b1);
        // Enable set then clear; frequency write to channel 0.
        send_frame(C_E, 8'd1, 16'h0001, 1'b1);
        send_frame(C_E, 8'd1, 16'h0000, 1'b1);
        send_frame(C_F, 8'd0, 16'h000A, 1'b1);

        // Invalid command byte, then a good frame.
        send_byte(8'h58);
        push(1'b1, last_cyc);
        send_frame(C_D, 8'd1, 16'hBEEF, 1'b1);

        // Out-of-range channel consumes the whole frame.
        send_frame(C_D, 8'd7, 16'hAABB, 1'b1);
        send_frame(C_F, 8'd3, 16'h0102, 1'b1);

        // Timeout mid-value: error TO cycles after last byte, no write.
        send_byte(C_D);
        send_byte(8'd3);
        send_byte(8'h55);
        push(1'b1, last_cyc + TO);
        idle(60);
        send_frame(C_D, 8'd3, 16'h0777, 1'b1);

        // Byte arriving on the would-be expiry cycle wins.
        send_byte(C_E);
        send_byte(8'd2);
        idle(TO - 1);
        send_byte(8'h01);
`ifdef CMD_CHECKSUM_EN
        send_byte(8'h46);
`endif
        m_en[2] = 1'b1;
        push(1'b0, last_cyc);

        // Reset mid-frame clears everything.
        send_byte(C_F);
        send_byte(8'd1);
        rst = 1'b1;
        idle(1);
        cmp("midframe_reset_duty", duty_cycle, 64'd0);
        cmp("midframe_reset_freq", freq_div, 64'd0);
        cmp("midframe_reset_en", {60'd0, enable_pwm}, 64'd0);
        rst = 1'b0;
        model_clear();
        send_frame(C_E, 8'd0, 16'h0001, 1'b1);

`ifdef CMD_CHECKSUM_EN
        send_frame(C_D, 8'd0, 16'h0102, 1'b1);
        send_frame(C_D, 8'd0, 16'h0304, 1'b0);
`endif

        idle(5);
        cmp("scoreboard_drained", 64'(sbq.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
